// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction word at a time
// from instruction memory over a req/ready handshake, and presents the latched
// word to the single-cycle control unit until the core acknowledges it.
//
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-low reset
//   imem_req/addr     - fetch request and address (address always equals pc)
//   imem_ready/rdata  - memory response; only honoured while imem_req is high
//   instr_ack, stall  - core done with current instruction / hold it
//   redirect(_pc)     - taken branch/jump target, sampled on an accepting ack
//   instr, opCode     - presented instruction, forced to zero while invalid
//   pc, pc_plus4      - address of presented instruction and its successor
//   instr_valid       - instr/opCode/pc are valid
//   fetch_misalign    - only with FETCH_MISALIGN_TRAP_EN: sticky trap flag
//
// Build option FETCH_MISALIGN_TRAP_EN: a misaligned accepted redirect sets a
// sticky fetch_misalign flag and halts fetching until reset. Without it the
// low two target bits are dropped and fetching continues.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h0040_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              instr_ack,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic [6:0]        opCode,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              fetch_misalign
`endif
);

  typedef enum logic [1:0] {StBoot, StFetch, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              halt;

  assign pc_inc       = pc_q + ADDR_W'(4);
  // Word-aligned target; the low two bits are never used as a fetch address.
  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic redirect_misaligned;

  assign redirect_misaligned = redirect && (redirect_pc[1:0] != 2'b00);
  assign halt                = misalign_q;
  assign fetch_misalign      = misalign_q;
`else
  assign halt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
        req_d   = 1'b1;
      end
      StFetch, StWait: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = StHold;
        end else begin
          state_d = StWait;
        end
      end
      StHold: begin
        // Stall takes priority over ack; redirect only matters on acceptance.
        if (!halt && instr_ack && !stall) begin
          valid_d = 1'b0;
          pc_d    = redirect ? redirect_tgt : pc_inc;
          state_d = StFetch;
          req_d   = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (redirect_misaligned) begin
            // Park in HOLD with nothing valid; only reset leaves this.
            misalign_d = 1'b1;
            state_d    = StHold;
            req_d      = 1'b0;
          end
`endif
        end
      end
      default: begin
        state_d = StBoot;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_inc;
  assign instr_valid = valid_q;
  // Zeroed while invalid so the control unit decodes its inactive default.
  assign instr       = valid_q ? instr_q : '0;
  assign opCode      = valid_q ? instr_q[6:0] : 7'b0000000;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the single-cycle control unit and datapath. It owns the PC and issues one fetch per instruction to instruction memory over a req/ready handshake. It latches the returned word and presents instr/opCode to the control unit. It advances the PC, or redirects it on branch/jump, when the core acknowledges the instruction and no stall (e.g. a UART wait) is active.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset
ADDR_W, 32, PC / imem address width
DATA_W, 32, instruction word width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address (equals pc)
imem_ready  in  1  memory returns imem_rdata this cycle
imem_rdata  in  DATA_W  fetched instruction word
instr_ack  in  1  core has finished executing current instr
stall  in  1  hold current instruction, no PC update
redirect  in  1  take redirect_pc instead of pc+4 (branch/jump taken)
redirect_pc  in  ADDR_W  branch/jump target
instr  out  DATA_W  latched instruction; 0 when instr_valid=0
opCode  out  7  instr[6:0]; 7'b0000000 when instr_valid=0
pc  out  ADDR_W  address of the presented instruction
pc_plus4  out  ADDR_W  pc+4, modulo 2^ADDR_W
instr_valid  out  1  instr/opCode/pc are valid

Behaviour:
- Reset (rst=0, async): state=BOOT, pc=RESET_PC, imem_req=0, instr=0, instr_valid=0. imem_req drops immediately, including mid-WAIT.
- FSM states: BOOT, FETCH, WAIT, HOLD.
- BOOT: one cycle after rst deasserts, go to FETCH. All outputs stay at reset values.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=1 in the same cycle: latch imem_rdata into instr; instr_valid=1 next cycle; go to HOLD.
  - Otherwise go to WAIT.
- WAIT: imem_req stays 1 and imem_addr stays stable until imem_ready. On ready, latch and go to HOLD.
- imem_ready while imem_req=0 is ignored.
- HOLD: imem_req=0, instr_valid=1, instr/pc stable.
  - instr_ack=1 and stall=0: next pc = redirect ? redirect_pc : pc+4; instr_valid=0; go to FETCH.
  - stall=1: stays in HOLD regardless of instr_ack or redirect (stall wins).
- redirect and redirect_pc are sampled only on an accepting instr_ack in HOLD. They are ignored in all other states and cycles.
- Minimum fetch latency: FETCH to instr_valid is 1 cycle. Throughput: at most one instruction per 2 cycles (HOLD, then FETCH).
- pc+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- Invalid output: opCode=0 while instr_valid=0, so the control unit decodes its default case (all controls inactive) during fetch bubbles.
- Misaligned redirect (redirect_pc[1:0]!=0): handling is defined under Optional Feature.

Optional Feature:
Macro: FETCH_MISALIGN_TRAP_EN
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A misaligned accepted redirect loads pc with redirect_pc[1:0] forced to 2'b00.
  - fetch_misalign is set sticky until reset.
  - The FSM enters HOLD with instr_valid=0 and stops fetching (halt) until reset.
- Undefined:
  - Port absent.
  - Low two bits are silently forced to 0.
  - Fetch continues from the aligned address.

Test Plan:
- Reset release, imem_ready=1 always -> first imem_addr=32'h0040_0000; instr_valid=1 one cycle after FETCH; opCode=imem_rdata[6:0]; opCode=0 during BOOT.
- imem_ready delayed 3 cycles -> imem_req held high and imem_addr constant for 4 cycles; instr latched only on the ready cycle.
- In HOLD, instr_ack=1, redirect=1, redirect_pc=32'h0040_0100 -> next imem_addr=32'h0040_0100. With redirect=0 -> 32'h0040_0004.
- In HOLD, instr_ack=1 and stall=1 for 5 cycles -> pc, instr and instr_valid unchanged; advances on the first cycle with stall=0.
- pc=32'hFFFF_FFFC, ack without redirect -> next fetch at 32'h0000_0000; pc_plus4 at 32'hFFFF_FFFC reads 0.
- rst pulled low during WAIT -> imem_req=0 immediately; after release, fetch restarts at RESET_PC. With FETCH_MISALIGN_TRAP_EN defined, redirect_pc=32'h0040_0102 -> fetch_misalign=1, no further imem_req.
